// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural order out.
// Writer scatters to bitrev addresses; reader streams each full bank linearly.
module fft_bitrev_reorder #(
  parameter int DATA_NUM   = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_i_en,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_o_en,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] data_o_idx,
  output logic                  data_o_sop,
  output logic                  data_o_eop
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] r;
    for (int k = 0; k < ADDR_WIDTH; k++)
      r[ADDR_WIDTH-1-k] = a[k];
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [2*DATA_NUM];
  logic [DATA_WIDTH-1:0] rdata;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt, rd_cnt_nxt;
  logic                  wr_bank, rd_bank, rd_bank_nxt;
  logic [1:0]            full, full_nxt;
  logic                  wr_last, rd_act;

  assign wr_last = data_i_en && (wr_cnt == LAST);

  always_ff @(posedge clk) begin
    if (data_i_en)
      mem[{wr_bank, bitrev(wr_cnt)}] <= data_i;
    rdata <= mem[{rd_bank, rd_cnt}];
  end

  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    full_nxt    = full;
    rd_act      = 1'b0;
    unique case (state)
      IDLE: begin
        rd_cnt_nxt = '0;
        if (full[rd_bank])
          state_nxt = READ;
      end
      READ: begin
        rd_act     = 1'b1;
        rd_cnt_nxt = rd_cnt + ONE;
        if (rd_cnt == LAST) begin
          full_nxt[rd_bank] = 1'b0;
          rd_bank_nxt       = ~rd_bank;
          // other bank may be completed by the writer on this very edge
          if (!(full[~rd_bank] || (wr_last && (wr_bank != rd_bank))))
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wr_last)
      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      data_o_en  <= 1'b0;
      data_o_idx <= '0;
      data_o_sop <= 1'b0;
      data_o_eop <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
      full    <= full_nxt;
      if (data_i_en) begin
        wr_cnt <= wr_cnt + ONE;
        if (wr_last)
          wr_bank <= ~wr_bank;
      end
      data_o_en  <= rd_act;
      data_o_idx <= rd_act ? rd_cnt : '0;
      data_o_sop <= rd_act && (rd_cnt == '0);
      data_o_eop <= rd_act && (rd_cnt == LAST);
    end
  end

  assign data_o = data_o_en ? rdata : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: frames in bitrev order,
// expected natural-order samples queued per frame and checked on output.
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_i_en = 1'b0;
  logic [63:0] data_i = '0;
  logic        data_o_en;
  logic [63:0] data_o;
  logic [9:0]  data_o_idx;
  logic        data_o_sop;
  logic        data_o_eop;

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .data_i_en (data_i_en),
    .data_i    (data_i),
    .data_o_en (data_o_en),
    .data_o    (data_o),
    .data_o_idx(data_o_idx),
    .data_o_sop(data_o_sop),
    .data_o_eop(data_o_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [9:0]  i;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   run = 0;
  int   max_run = 0;
  exp_t e;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] brv(logic [9:0] x);
    logic [9:0] r;
    for (int k = 0; k < 10; k++)
      r[k] = x[9-k];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_o_en) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        chk("unexp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data", data_o, e.d);
        chk("idx", {54'd0, data_o_idx}, {54'd0, e.i});
        chk("sop", {63'd0, data_o_sop}, {63'd0, e.i == 10'd0});
        chk("eop", {63'd0, data_o_eop}, {63'd0, e.i == 10'd1023});
      end
      if (data_o_sop) begin
        if (lat_q.size() != 0) chk("lat", cyc, lat_q.pop_front());
        else chk("lat_none", 1, 0);
      end
    end else begin
      run = 0;
      chk("idle_d", data_o, 0);
      chk("idle_m", {52'd0, data_o_idx, data_o_sop, data_o_eop}, 0);
    end
  end

  // mode 0: {bitrev(n),bitrev(n)}; 1: random; 2: random with negative at bitrev(5)
  task automatic send(int nfr, int mode, bit gap);
    logic [63:0] fr[1024];
    logic [63:0] v;
    exp_t x;
    for (int f = 0; f < nfr; f++) begin
      for (int n = 0; n < 1024; n++) begin
        if (mode == 0)
          v = {22'd0, brv(10'(n)), 22'd0, brv(10'(n))};
        else if (mode == 2 && n == int'(brv(10'd5)))
          v = 64'hFFFF_FFFF_8000_0000;
        else
          v = {$urandom, $urandom};
        fr[n] = v;
        @(negedge clk);
        if (gap && n > 0) begin
          data_i_en = 1'b0;
          @(negedge clk);
        end
        data_i_en = 1'b1;
        data_i = v;
        if (n == 1023) begin
          lat_q.push_back(cyc + 3);
          for (int k = 0; k < 1024; k++) begin
            x.i = 10'(k);
            x.d = (mode == 0) ? {22'd0, 10'(k), 22'd0, 10'(k)}
                              : fr[brv(10'(k))];
            exp_q.push_back(x);
          end
        end
      end
    end
    @(negedge clk);
    data_i_en = 1'b0;
  endtask

  task automatic drain(int budget);
    int w = 0;
    while (exp_q.size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_en", {63'd0, data_o_en}, 0);
    chk("rst_d", data_o, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send(1, 0, 1'b0);
    drain(1200);

    max_run = 0;
    send(3, 1, 1'b0);
    drain(1200);
    chk("run", max_run, 3072);

    send(1, 0, 1'b1);
    drain(1200);

    send(1, 2, 1'b0);
    drain(1200);

    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      data_i_en = 1'b1;
      data_i = {$urandom, $urandom};
    end
    @(negedge clk);
    data_i_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(1, 1, 1'b0);
    drain(1200);

    send(1, 1, 1'b0);
    w = 0;
    while (!(data_o_en && data_o_idx == 10'd300) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("wait300", {63'd0, w < 2000}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_en", {63'd0, data_o_en}, 0);
    chk("arst_d", data_o, 0);
    chk("arst_m", {52'd0, data_o_idx, data_o_sop, data_o_eop}, 0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    send(1, 0, 1'b0);
    drain(1200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter DATA_NUM, default 1024: FFT frame length; SHALL be a power of two.
REQ-002 Parameter DATA_WIDTH, default 64: sample width; [DATA_WIDTH-1:DATA_WIDTH/2] = real, [DATA_WIDTH/2-1:0] = imag.
REQ-003 Parameter ADDR_WIDTH, default 10: log2(DATA_NUM).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_i_en  input  1  input sample valid; one sample accepted per clk edge where high.
REQ-007 data_i  input  DATA_WIDTH  FFT output sample, bit-reversed index order.
REQ-008 data_o_en  output  1  output sample valid.
REQ-009 data_o  output  DATA_WIDTH  reordered sample, natural index order.
REQ-010 data_o_idx  output  ADDR_WIDTH  natural frequency index of data_o.
REQ-011 data_o_sop  output  1  high with index 0 of a frame.
REQ-012 data_o_eop  output  1  high with index DATA_NUM-1 of a frame.

Function
REQ-013 Storage SHALL be two banks (ping-pong) of DATA_NUM x DATA_WIDTH each.
REQ-014 Write counter wr_cnt (ADDR_WIDTH bits) SHALL increment on each accepted sample, wrapping DATA_NUM-1 -> 0.
REQ-015 Accepted sample SHALL be written to wr_bank at address bitrev(wr_cnt) (bit k -> bit ADDR_WIDTH-1-k).
REQ-016 Gaps in data_i_en SHALL be tolerated; wr_cnt holds while data_i_en low.
REQ-017 On the accept with wr_cnt = DATA_NUM-1: set full[wr_bank], toggle wr_bank, same edge.
REQ-018 Reader FSM states: IDLE, READ.
REQ-019 IDLE -> READ when full[rd_bank] = 1; rd_cnt = 0 on entry.
REQ-020 In READ, memory SHALL be read at rd_bank/rd_cnt every cycle, rd_cnt incrementing by 1, no stalls.
REQ-021 At rd_cnt = DATA_NUM-1: clear full[rd_bank], toggle rd_bank; if full[other bank] is set (including set on this same edge) stay READ with rd_cnt = 0, else -> IDLE.
REQ-022 Memory read SHALL be registered: data_o/data_o_idx/sop/eop/data_o_en valid one cycle after address issue.
REQ-023 Latency: last sample of a frame accepted at edge T -> index 0 on data_o after edge T+2.
REQ-024 Continuous input (data_i_en held high) SHALL give continuous output, no idle cycle between frames.
REQ-025 Writer never targets a full bank under REQ-024 rates; no backpressure port exists.
REQ-026 Simultaneous full-set (writer) and full-clear (reader) on different banks SHALL both take effect.
REQ-027 When data_o_en = 0, data_o, data_o_idx, data_o_sop, data_o_eop SHALL be 0.
REQ-028 Sample values SHALL pass unmodified (no scaling, rounding, sign change).

Reset
REQ-029 rst high SHALL asynchronously clear wr_cnt, rd_cnt, wr_bank, rd_bank, full[1:0], FSM to IDLE.
REQ-030 During and after reset all outputs SHALL be 0 until the next full frame is read.
REQ-031 Reset mid-frame or mid-read SHALL discard partial/pending frames; first frame after reset aligns to wr_cnt = 0.
REQ-032 Memory contents need not be cleared by reset.

Verification
REQ-033 Single frame, data_i = {bitrev(n), bitrev(n)} for n = 0..1023 continuous -> data_o = {k,k}, data_o_idx = k, k = 0..1023, sop at k=0, eop at k=1023, first output 2 cycles after last input.
REQ-034 Three back-to-back frames continuous -> 3072 consecutive data_o_en cycles, no gap, each frame correctly ordered.
REQ-035 Frame with data_i_en low every other cycle -> output identical to REQ-033, output starts 2 cycles after 1024th accept.
REQ-036 Negative values, real = -1 (0xFFFFFFFF), imag = 0x80000000 at bitrev(5) -> index 5 outputs 0xFFFFFFFF_80000000 exactly.
REQ-037 rst pulsed after 500 samples of frame 1, then full frame 2 -> no output from frame 1; frame 2 correctly ordered.
REQ-038 rst pulsed mid-read at index 300 -> data_o_en falls to 0 asynchronously, all outputs 0, no further output until a new full frame.
